// File: rtl/mdu_seq.sv
// Multiply/divide sequencer owning HI/LO: captures the result at start, holds a fixed
// busy window, then commits to HI/LO (skipped for divide-by-zero).
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        D_md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_tmp, lo_tmp;
  logic          div_zero;

  logic signed [63:0] a_s, b_s, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor, a_mag, b_mag, q_mag, r_mag;
  logic [31:0]        q_s, r_s, q_u, r_u;
  logic [31:0]        res_hi, res_lo;
  logic               is_div;

  assign E_start    = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && !E_busy;
  assign D_md_stall = D_md_use & (E_start | E_busy);
  assign is_div     = (E_md_op == OP_DIV) || (E_md_op == OP_DIVU);

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    a_s     = {{32{E_A[31]}}, E_A};
    b_s     = {{32{E_B[31]}}, E_B};
    prod_s  = a_s * b_s;
    prod_u  = {32'd0, E_A} * {32'd0, E_B};
    divisor = (E_B == 32'd0) ? 32'd1 : E_B;
    a_mag   = E_A[31] ? -E_A : E_A;
    b_mag   = divisor[31] ? -divisor : divisor;
    q_mag   = a_mag / b_mag;
    r_mag   = a_mag % b_mag;
    q_s     = (E_A[31] ^ divisor[31]) ? -q_mag : q_mag;
    r_s     = E_A[31] ? -r_mag : r_mag;
    q_u     = E_A / divisor;
    r_u     = E_A % divisor;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    case (E_md_op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
      OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      E_busy   <= 1'b0;
      cnt      <= '0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (E_start) begin
            hi_tmp   <= res_hi;
            lo_tmp   <= res_lo;
            cnt      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            div_zero <= is_div && (E_B == 32'd0);
            E_busy   <= 1'b1;
            state    <= RUN;
          end else if (E_md_op == OP_MTHI) begin
            HI <= E_A;
          end else if (E_md_op == OP_MTLO) begin
            LO <= E_A;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (!div_zero) begin
              HI <= hi_tmp;
              LO <= lo_tmp;
            end
            cnt    <= '0;
            E_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares whenever the busy window closes.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_md_op;
  logic [31:0] E_A, E_B;
  logic        D_md_use;
  logic        E_start, E_busy, D_md_stall;
  logic [31:0] HI, LO;

  mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_A(E_A), .E_B(E_B),
    .D_md_use(D_md_use), .E_start(E_start), .E_busy(E_busy),
    .HI(HI), .LO(LO), .D_md_stall(D_md_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  logic [31:0] cur_hi, cur_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: HI/LO must hold during busy; on busy fall, result and window length are checked.
  logic prev_busy = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (E_busy === 1'b1) begin
      bcnt++;
      if (sb.size() == 0) chk("busy_without_entry", 32'd1, 32'd0);
      else begin
        chk("hold_hi", HI, sb[0].prev_hi);
        chk("hold_lo", LO, sb[0].prev_lo);
      end
    end else if (prev_busy) begin
      if (sb.size() == 0) chk("commit_without_entry", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_hi", HI, e.hi);
        chk("commit_lo", LO, e.lo);
        chk("busy_len", bcnt, e.n);
      end
      bcnt = 0;
    end
    prev_busy = E_busy;
  end

  always @(negedge clk) stall_cnt += int'(D_md_stall);

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int n);
    @(posedge clk); #1;
    E_md_op = op; E_A = a; E_B = b;
    sb.push_back('{ehi, elo, cur_hi, cur_lo, n});
    @(negedge clk);
    chk("start", {31'd0, E_start}, 32'd1);
    @(posedge clk); #1;
    E_md_op = 3'd0;
    cur_hi = ehi; cur_lo = elo;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!E_busy) done = 1;
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    E_md_op = op; E_A = a;
    @(posedge clk); #1;
    E_md_op = 3'd0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; E_md_op = 3'd0; E_A = 32'd0; E_B = 32'd0; D_md_use = 1'b1;
    cur_hi = 32'd0; cur_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, E_busy}, 32'd0);
    chk("rst_start", {31'd0, E_start}, 32'd0);
    chk("rst_stall", {31'd0, D_md_stall}, 32'd0);

    // mult -3 * 5 with D_md_use held: stall spans start cycle + 5 busy cycles
    stall_cnt = 0;
    issue(3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    wait_idle();
    chk("stall_len", stall_cnt, 32'd6);
    chk("stall_after", {31'd0, D_md_stall}, 32'd0);

    // multu max*max without D_md_use: never stalls
    D_md_use = 1'b0;
    stall_cnt = 0;
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    wait_idle();
    chk("no_stall", stall_cnt, 32'd0);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();

    move_to(3'b101, 32'hAAAA_5555);
    chk("mthi", HI, 32'hAAAA_5555);
    chk("mthi_lo_keep", LO, 32'hFFFF_FFFD);
    move_to(3'b101, 32'h1234_5678);
    move_to(3'b110, 32'h1234_5678);
    chk("mtlo", LO, 32'h1234_5678);
    cur_hi = 32'h1234_5678; cur_lo = 32'h1234_5678;

    // divu by zero: full window, no commit
    issue(3'b100, 32'd7, 32'd0, 32'h1234_5678, 32'h1234_5678, 10);
    wait_idle();

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    wait_idle();

    // back-to-back: multu held; operands change while busy, restart in first idle cycle
    @(posedge clk); #1;
    E_md_op = 3'b010; E_A = 32'd3; E_B = 32'd4;
    sb.push_back('{32'd0, 32'd12, cur_hi, cur_lo, 5});
    @(posedge clk); #1;
    E_A = 32'd5; E_B = 32'd6;
    sb.push_back('{32'd0, 32'd30, 32'd0, 32'd12, 5});
    cur_hi = 32'd0; cur_lo = 32'd30;
    wait_idle();
    chk("b2b_start", {31'd0, E_start}, 32'd1);
    @(posedge clk); #1;
    E_md_op = 3'd0;
    wait_idle();

    // mtlo and mult presented while busy are ignored
    issue(3'b001, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 5);
    @(posedge clk); #1;
    E_md_op = 3'b110; E_A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    E_md_op = 3'b001; E_A = 32'd1; E_B = 32'd1;
    @(negedge clk);
    chk("no_start_busy", {31'd0, E_start}, 32'd0);
    @(posedge clk); #1;
    E_md_op = 3'd0;
    wait_idle();
    chk("lo_after_ignored_mtlo", LO, 32'hFFFF_FFF2);

    // reset in the 4th busy cycle of a div aborts it
    issue(3'b011, 32'd100, 32'd7, 32'd0, 32'd0, 4);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, E_busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    chk("abort_busy_late", {31'd0, E_busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle multiply/divide sequencer for the five-stage pipeline CPU. It sits in the E stage beside the ALU and owns the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction, holds a busy window of fixed length, and commits results to HI/LO at the end of that window. It raises a stall request so the D stage freezes any HI/LO-class instruction until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, default 10: busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- E_md_op  input  3  E-stage operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- E_A  input  32  forwarded rs value (multiplicand / dividend / mthi-mtlo source).
- E_B  input  32  forwarded rt value (multiplier / divisor).
- D_md_use  input  1  D-stage instruction is any of mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- E_start  output  1  combinational; 1 when E_md_op ∈ {001..100} and E_busy=0.
- E_busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  registered HI register.
- LO  output  32  registered LO register.
- D_md_stall  output  1  combinational; D_md_use & (E_start | E_busy).

## Operation
- States: IDLE (busy=0) and RUN (busy=1, down-counter cnt > 0).
- IDLE, E_start=1: capture result of E_A op E_B into internal hi_tmp/lo_tmp, load cnt with MULT_CYCLES or DIV_CYCLES, record whether the op is a divide-by-zero; go to RUN.
- RUN: decrement cnt each cycle; at the edge where cnt=1, write hi_tmp/lo_tmp to HI/LO (skipped for divide-by-zero), clear busy, go to IDLE.
- E_md_op mult..divu while busy: ignored (cannot occur when the stall is honoured; the unit must not restart).
- mthi/mtlo: in IDLE, write E_A to HI/LO at the same edge; no busy. While busy: ignored.
- mult: signed 32×32 → 64; HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- divu: unsigned quotient → LO, remainder → HI.
- Divisor 0 (div or divu): full busy window still runs; HI and LO keep their previous values.
- mfhi/mflo read HI/LO outputs directly in E. The stall guarantees they never reach E while a result is pending.

## Timing
- Reset: HI=0, LO=0, E_busy=0, cnt=0. E_start and D_md_stall then follow inputs combinationally.
- Start accepted at edge t (E_start=1 in cycle before t). E_busy=1 for exactly N cycles after t (N = MULT_CYCLES or DIV_CYCLES). New HI/LO are visible, and E_busy=0, from the cycle after the N-th busy cycle.
- Back-to-back: a new start is accepted in the first cycle E_busy=0, with no bubble required inside the unit.
- D_md_stall is 1 in the start cycle and in all N busy cycles when D_md_use=1, and 0 otherwise. Non-md D instructions never stall.
- Reset asserted mid-RUN: operation is aborted, HI/LO go to 0, and no late commit occurs.
- mthi/mtlo: HI/LO change at the edge ending the cycle they are presented in IDLE.

## Test plan
- Reset, then mult E_A=0xFFFFFFFD (−3), E_B=5 → E_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO unchanged during busy.
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
- div −7/2 (0xFFFFFFF9, 2) → 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=LO=0x12345678 → 10 busy cycles, HI/LO still 0x12345678.
- D_md_use=1 held during mult start → D_md_stall=1 for start cycle + 5 busy cycles, 0 next. Repeat with D_md_use=0 → D_md_stall stays 0.
- mthi 0xAAAA5555 in IDLE → HI=0xAAAA5555 next cycle. mtlo presented while busy → LO ignored, and the later mult result commits normally.
- Start div, assert reset in 4th busy cycle → HI=LO=0, E_busy=0 next cycle, no commit at original end time.
